// File: rtl/mdu_pkg.sv
// Op codes and operation-class helpers shared by the multiply/divide unit.
// Defining MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU codes.
`ifndef MDUOPlen
`define MDUOPlen 4
`endif

package mdu_pkg;
    localparam int MDU_OP_W     = `MDUOPlen;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef logic [MDU_OP_W-1:0] mdu_op_t;

    localparam mdu_op_t MDU_NONE  = mdu_op_t'(0);
    localparam mdu_op_t MDU_MULT  = mdu_op_t'(1);
    localparam mdu_op_t MDU_MULTU = mdu_op_t'(2);
    localparam mdu_op_t MDU_DIV   = mdu_op_t'(3);
    localparam mdu_op_t MDU_DIVU  = mdu_op_t'(4);
    localparam mdu_op_t MDU_MFHI  = mdu_op_t'(5);
    localparam mdu_op_t MDU_MFLO  = mdu_op_t'(6);
    localparam mdu_op_t MDU_MTHI  = mdu_op_t'(7);
    localparam mdu_op_t MDU_MTLO  = mdu_op_t'(8);
`ifdef MDU_MADD_EN
    localparam mdu_op_t MDU_MADD  = mdu_op_t'(9);
    localparam mdu_op_t MDU_MADDU = mdu_op_t'(10);
    localparam mdu_op_t MDU_MSUB  = mdu_op_t'(11);
    localparam mdu_op_t MDU_MSUBU = mdu_op_t'(12);
`endif

    function automatic logic op_is_mul(input mdu_op_t op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Unsigned variants carry the U suffix; everything else multi-cycle is signed.
    function automatic logic op_is_signed(input mdu_op_t op);
        case (op)
            MDU_MULT, MDU_DIV: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mdu_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_if
    import mdu_pkg::*;
;
    logic        start;
    logic        flush;
    mdu_op_t     op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    modport master (
        output start, flush, op, rs, rt,
        input  busy, hi, lo, out
    );

    modport slave (
        input  start, flush, op, rs, rt,
        output busy, hi, lo, out
    );
endinterface

// File: rtl/mdu_core.sv
// Combinational arithmetic for the MDU: product, quotient/remainder, divide-by-zero flag.
// With MDU_MADD_EN the product is also accumulated into the supplied HI:LO value.
module mdu_core
    import mdu_pkg::*;
(
    input  mdu_op_t     op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MDU_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] res,
    output logic        div_zero
);
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] b_safe;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quo;
    logic        [31:0] rem;

    always_comb begin
        sgn      = op_is_signed(op);
        a_neg    = sgn & rs[31];
        b_neg    = sgn & rt[31];
        // One 64x64 multiplier serves both signednesses: the low 64 bits are exact either way.
        a_ext    = {{32{a_neg}}, rs};
        b_ext    = {{32{b_neg}}, rt};
        prod     = a_ext * b_ext;
        div_zero = (rt == 32'd0);
        a_mag    = a_neg ? -rs : rs;
        b_mag    = b_neg ? -rt : rt;
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        // Truncation toward zero; remainder follows the dividend. 0x80000000/-1 wraps to 0x80000000.
        quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;
        res      = prod;
        if (op_is_div(op)) begin
            res = {rem, quo};
        end
`ifdef MDU_MADD_EN
        else if ((op == MDU_MADD) || (op == MDU_MADDU)) begin
            res = acc + prod;
        end else if ((op == MDU_MSUB) || (op == MDU_MSUBU)) begin
            res = acc - prod;
        end
`endif
    end
endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: HI/LO state, fixed-latency busy counter, MFHI/MFLO read mux.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_vld;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        accept;
    logic [63:0] core_res;
    logic        div_zero;

    assign busy   = (cnt != 4'd0);
    assign accept = bus.start & ~bus.flush & ~busy;

    mdu_core u_core (
        .op       (bus.op),
        .rs       (bus.rs),
        .rt       (bus.rt),
`ifdef MDU_MADD_EN
        .acc      ({hi, lo}),
`endif
        .res      (core_res),
        .div_zero (div_zero)
    );

    // The result is captured at accept and held until the counter's 1->0 step commits it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= 4'd0;
            pend     <= 64'd0;
            pend_vld <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                if (pend_vld) begin
                    {hi, lo} <= pend;
                end
                pend_vld <= 1'b0;
            end
        end else if (accept) begin
            if (op_is_mul(bus.op)) begin
                pend     <= core_res;
                pend_vld <= 1'b1;
                cnt      <= MULT_CNT;
            end else if (op_is_div(bus.op)) begin
                pend     <= core_res;
                pend_vld <= ~div_zero;
                cnt      <= DIV_CNT;
            end else if (bus.op == MDU_MTHI) begin
                hi <= bus.rs;
            end else if (bus.op == MDU_MTLO) begin
                lo <= bus.rs;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
    assign bus.out  = (bus.op == MDU_MFHI) ? hi : lo;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a driver applies directed and random ops against a behavioural
// HI/LO model and queues expected completions; a monitor checks them. MDU_MADD_EN selects the MADD build.
`timescale 1ns/1ps
module tb_mdu;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic rst_req = 1'b1;

    mdu_if bus();

    mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    exp_t        mq[$];
    exp_t        iq[$];
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;
    int          mcnt = 0;
    bit          abort_seen = 1'b0;
    logic [31:0] last_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(int'(a)) * longint'(int'(b));
        return p;
    endfunction

    function automatic logic [63:0] uprod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        return p;
    endfunction

    task automatic launch(input logic [63:0] v, input int lat);
        {mhi, mlo} = v;
        mcnt = lat;
        mq.push_back('{mhi, mlo, lat});
    endtask

    // Architectural model: what HI:LO become once an accepted op completes.
    task automatic model_edge(input logic st, input logic fl, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        bit     acc;
        longint q;
        longint r;
        if (!reset) begin
            abort_seen = (mcnt != 0);
            mcnt = 0;
            mhi  = 32'd0;
            mlo  = 32'd0;
            mq.delete();
            iq.delete();
            return;
        end
        acc = st && !fl && (mcnt == 0);
        if (mcnt > 0) mcnt--;
        if (!acc) return;
        case (o)
            OP_MULT:  launch(sprod(a, b), MULT_LAT);
            OP_MULTU: launch(uprod(a, b), MULT_LAT);
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    launch({mhi, mlo}, DIV_LAT);
                end else begin
                    if (o == OP_DIV) begin
                        q = longint'(int'(a)) / longint'(int'(b));
                        r = longint'(int'(a)) % longint'(int'(b));
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    launch({r[31:0], q[31:0]}, DIV_LAT);
                end
            end
            OP_MTHI: begin mhi = a; iq.push_back('{mhi, mlo, 0}); end
            OP_MTLO: begin mlo = a; iq.push_back('{mhi, mlo, 0}); end
`ifdef MDU_MADD_EN
            OP_MADD:  launch({mhi, mlo} + sprod(a, b), MULT_LAT);
            OP_MADDU: launch({mhi, mlo} + uprod(a, b), MULT_LAT);
            OP_MSUB:  launch({mhi, mlo} - sprod(a, b), MULT_LAT);
            OP_MSUBU: launch({mhi, mlo} - uprod(a, b), MULT_LAT);
`endif
            default: ;
        endcase
    endtask

    task automatic cycle(input logic st, input logic fl, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset     = rst_req;
        bus.start = st;
        bus.flush = fl;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        #1;
        last_out = bus.out;
        check("busy", {31'd0, bus.busy}, {31'd0, mcnt != 0});
        if (mcnt == 0) check((o == OP_MFHI) ? "out_mfhi" : "out_mflo", bus.out, (o == OP_MFHI) ? mhi : mlo);
        @(posedge clk);
        model_edge(st, fl, o, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && mcnt != 0; i++) idle(1);
    endtask

    task automatic expect_hl(input string name, input logic [31:0] h, input logic [31:0] l);
        #2;
        check({name, "_hi"}, bus.hi, h);
        check({name, "_lo"}, bus.lo, l);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: each busy fall is one completion; immediate MTHI/MTLO writes are checked the cycle after.
    initial begin
        bit   prev_busy;
        int   run;
        exp_t e;
        prev_busy = 1'b0;
        run = 0;
        wait (reset == 1'b1);
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                run++;
            end else begin
                if (prev_busy) begin
                    if (abort_seen) begin
                        abort_seen = 1'b0;
                        check("abort_hi", bus.hi, 32'd0);
                        check("abort_lo", bus.lo, 32'd0);
                    end else if (mq.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL sb_completion: got busy fall, expected none pending");
                    end else begin
                        e = mq.pop_front();
                        check("sb_latency", 32'(run), 32'(e.lat));
                        check("sb_hi", bus.hi, e.hi);
                        check("sb_lo", bus.lo, e.lo);
                    end
                end
                run = 0;
                if (iq.size() != 0) begin
                    e = iq.pop_front();
                    check("mt_hi", bus.hi, e.hi);
                    check("mt_lo", bus.lo, e.lo);
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = OP_NONE;
        bus.rs    = 32'd0;
        bus.rt    = 32'd0;
        repeat (2) @(posedge clk);
        rst_req = 1'b1;
        idle(1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_out", last_out, 32'd0);
        expect_hl("reset", 32'd0, 32'd0);

        cycle(1'b1, 1'b0, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        cycle(1'b1, 1'b0, OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        expect_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        cycle(1'b1, 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        cycle(1'b1, 1'b0, OP_DIVU, 32'd7, 32'd0);
        wait_idle();
        expect_hl("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        cycle(1'b1, 1'b0, OP_MTHI, 32'h0000_1234, 32'd0);
        cycle(1'b1, 1'b0, OP_MFHI, 32'd0, 32'd0);
        check("mfhi_out", last_out, 32'h0000_1234);
        cycle(1'b1, 1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        idle(1);
        check("mtlo_flush_busy", {31'd0, bus.busy}, 32'd0);
        expect_hl("mtlo_flush", 32'h0000_1234, 32'hFFFF_FFFD);

        cycle(1'b1, 1'b0, OP_MULT, 32'd6, 32'd7);
        cycle(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7);
        wait_idle();
        expect_hl("busy_ignore", 32'd0, 32'd42);
        cycle(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7);
        wait_idle();
        expect_hl("reissue", 32'd2, 32'd14);

        cycle(1'b1, 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        expect_hl("div_ovf", 32'd0, 32'h8000_0000);

        cycle(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7);
        idle(2);
        rst_req = 1'b0;
        idle(1);
        rst_req = 1'b1;
        idle(1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        expect_hl("abort_now", 32'd0, 32'd0);
        idle(10);
        expect_hl("abort_late", 32'd0, 32'd0);

        cycle(1'b1, 1'b0, OP_MTHI, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, OP_MTLO, 32'd1, 32'd0);
        cycle(1'b1, 1'b0, OP_MADD, 32'd2, 32'd3);
        idle(6);
`ifdef MDU_MADD_EN
        expect_hl("madd", 32'd0, 32'd7);
`else
        expect_hl("madd_off", 32'd0, 32'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
        end
        wait_idle();
        idle(2);
        check("sb_drained", 32'(mq.size() + iq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
